// File: rtl/pkt_rd_sched_pkg.sv
`default_nettype none
// ============================================================================
// pkt_rd_sched_pkg : shared types and CSR map for the descriptor scheduler
// Rev 1.0
// ============================================================================
package pkt_rd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [2:0] CSR_DESC_BEGIN = 3'd0;
  localparam logic [2:0] CSR_DESC_END   = 3'd1;
  localparam logic [2:0] CSR_CONTROL    = 3'd2;
  localparam logic [2:0] CSR_STATUS     = 3'd3;
  localparam logic [2:0] CSR_DONE_COUNT = 3'd4;
  localparam logic [2:0] CSR_DROP_COUNT = 3'd5;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_IRQ_CLR = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_TIMEOUT = 3;

  typedef struct packed {
    logic [31:0] begin_addr;
    logic [31:0] end_addr;
  } desc_t;

  function automatic logic desc_valid(input desc_t d);
    return d.end_addr > d.begin_addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_rd_sched_desc_fifo.sv
`default_nettype none
// ============================================================================
// desc_fifo : DEPTH x 64 synchronous descriptor FIFO, first-word-fall-through
// Rev 1.0
// ============================================================================
module desc_fifo
  import pkt_rd_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  desc_t      data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output desc_t      head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  desc_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Full is judged on the current occupancy, so a simultaneous pop never frees room for a push.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = 8'(count_q);

endmodule
`default_nettype wire

// File: rtl/pkt_rd_sched.sv
`default_nettype none
// ============================================================================
// pkt_rd_sched : CSR-fed descriptor queue feeding the packet read engine
// Optional WAIT watchdog: define PKT_SCHED_TIMEOUT_EN.          Rev 1.0
// ============================================================================
module pkt_rd_sched
  import pkt_rd_sched_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  output logic        eng_start,
  output logic [31:0] eng_control,
  output logic [31:0] eng_pkt_begin,
  output logic [31:0] eng_pkt_end,
  input  logic        eng_done,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [31:0] staged_begin_q, done_cnt_q, drop_cnt_q, rdata_q, rd_mux;
  logic [31:0] eng_begin_q, eng_end_q, eng_ctrl_q;
  logic [15:0] ctrl_word_q;
  logic        enable_q, irq_en_q, irq_pending_q, irq_q;
  logic        push_req, ctrl_wr, flush, pop, done_evt, timeout_evt, timeout_hit, timeout_q;
  logic        fifo_full, fifo_empty;
  logic [7:0]  occupancy;
  desc_t       new_desc, head;

  assign new_desc = '{begin_addr: staged_begin_q, end_addr: csr_writedata};
  assign push_req = csr_write && (csr_address == CSR_DESC_END);
  assign ctrl_wr  = csr_write && (csr_address == CSR_CONTROL);
  assign flush    = ctrl_wr && csr_writedata[CTRL_FLUSH];

  desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req && desc_valid(new_desc)),
    .data_i  (new_desc),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      // A same-cycle flush would leave LOAD popping an empty queue.
      ST_IDLE:  if (enable_q && !fifo_empty && !flush) state_d = ST_LOAD;
      ST_LOAD: begin
        pop     = 1'b1;
        state_d = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          done_evt = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          timeout_evt = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PKT_SCHED_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == ST_START)     wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;
      if (timeout_evt)                                  timeout_q <= 1'b1;
      else if (ctrl_wr && csr_writedata[CTRL_ENABLE])   timeout_q <= 1'b0;
    end
  end

  assign timeout_hit = (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_q          = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_DESC_BEGIN: rd_mux = staged_begin_q;
      CSR_CONTROL:    rd_mux = {ctrl_word_q, 12'h000, irq_en_q, 2'b00, enable_q};
      CSR_STATUS:     rd_mux = {16'h0000, occupancy, 4'h0, timeout_q, fifo_empty,
                                fifo_full, state_q != ST_IDLE};
      CSR_DONE_COUNT: rd_mux = done_cnt_q;
      CSR_DROP_COUNT: rd_mux = drop_cnt_q;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      staged_begin_q <= '0;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      ctrl_word_q    <= '0;
      done_cnt_q     <= '0;
      drop_cnt_q     <= '0;
      irq_pending_q  <= 1'b0;
      irq_q          <= 1'b0;
      eng_begin_q    <= '0;
      eng_end_q      <= '0;
      eng_ctrl_q     <= '0;
      rdata_q        <= '0;
    end else begin
      if (csr_write && (csr_address == CSR_DESC_BEGIN)) staged_begin_q <= csr_writedata;
      if (ctrl_wr) begin
        enable_q    <= csr_writedata[CTRL_ENABLE];
        irq_en_q    <= csr_writedata[CTRL_IRQ_EN];
        ctrl_word_q <= csr_writedata[31:16];
      end
      if (timeout_evt) enable_q <= 1'b0;
      if (push_req && (fifo_full || !desc_valid(new_desc))) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (done_evt) done_cnt_q <= done_cnt_q + 32'd1;
      if (done_evt || timeout_evt)                     irq_pending_q <= 1'b1;
      else if (ctrl_wr && csr_writedata[CTRL_IRQ_CLR]) irq_pending_q <= 1'b0;
      irq_q <= irq_pending_q & irq_en_q;
      if (state_q == ST_LOAD) begin
        eng_begin_q <= head.begin_addr;
        eng_end_q   <= head.end_addr;
        eng_ctrl_q  <= {16'h0000, ctrl_word_q};
      end
      if (csr_read) rdata_q <= rd_mux;
    end
  end

  assign csr_readdata  = rdata_q;
  assign eng_start     = (state_q == ST_START);
  assign eng_control   = eng_ctrl_q;
  assign eng_pkt_begin = eng_begin_q;
  assign eng_pkt_end   = eng_end_q;
  assign irq           = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_rd_sched.sv
`default_nettype none
// ============================================================================
// tb_pkt_rd_sched : self-checking bench for pkt_rd_sched
// Rev 1.0
// ============================================================================
module tb_pkt_rd_sched;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        eng_start;
  logic [31:0] eng_control;
  logic [31:0] eng_pkt_begin;
  logic [31:0] eng_pkt_end;
  logic        eng_done;
  logic        irq;

  always #5 clk = ~clk;

  pkt_rd_sched #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .eng_start     (eng_start),
    .eng_control   (eng_control),
    .eng_pkt_begin (eng_pkt_begin),
    .eng_pkt_end   (eng_pkt_end),
    .eng_done      (eng_done),
    .irq           (irq)
  );

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
  } exp_t;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    bit          acc;
    int          occ;
    int          drop;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_start = -1;
  exp_t        sb[$];
  exp_t        mon_x;
  logic [31:0] exp_ctrl = '0;
  bit          resp_en = 1'b0;
  int          done_dly = 5;
  vec_t        vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(negedge clk);
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clk);
    csr_read    = 1'b0;
    d           = csr_readdata;
  endtask

  task automatic push_desc(input logic [31:0] b, input logic [31:0] e, input bit acc);
    exp_t x;
    csr_wr(3'd0, b);
    csr_wr(3'd1, e);
    x.b = b;
    x.e = e;
    if (acc) sb.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    bit          ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      csr_rd(3'd3, s);
      if (!s[0] && s[2] && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_idle"}, {31'd0, ok}, 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: answers each start with a done pulse done_dly cycles later.
  initial begin
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start && resp_en) begin
        repeat (done_dly - 1) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every start must match the oldest accepted descriptor.
  initial forever begin
    @(negedge clk);
    if (eng_start) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start actual=begin 0x%08h required=no start", eng_pkt_begin);
      end else begin
        mon_x = sb.pop_front();
        chk("start_begin", eng_pkt_begin, mon_x.b);
        chk("start_end", eng_pkt_end, mon_x.e);
        chk("start_control", eng_control, exp_ctrl);
      end
      if (last_start >= 0) chk("start_gap_ge3", {31'd0, (cyc - last_start) >= 3}, 32'd1);
      last_start = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic [31:0] d;

    vecs[0]  = '{32'h2000, 32'h2000, 1'b0, 0, 1};
    vecs[1]  = '{32'h0100, 32'h0180, 1'b1, 1, 1};
    vecs[2]  = '{32'h0300, 32'h02FF, 1'b0, 1, 2};
    for (int i = 0; i < 7; i++)
      vecs[3+i] = '{32'h4000 + 32'(i) * 32'h100, 32'h4080 + 32'(i) * 32'h100, 1'b1, 2 + i, 2};
    vecs[10] = '{32'h9000, 32'h9100, 1'b0, 8, 3};

    reset = 1'b0; csr_address = '0; csr_write = 1'b0; csr_writedata = '0; csr_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
    chk("rst_eng_control", eng_control, 32'd0);
    chk("rst_eng_begin", eng_pkt_begin, 32'd0);
    chk("rst_eng_end", eng_pkt_end, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    csr_rd(3'd3, s);
    chk("rst_status", s, 32'h4);

    // Single descriptor, done 20 cycles after start, interrupt enabled.
    exp_ctrl = 32'h0000A5A5;
    resp_en = 1'b1; done_dly = 20;
    csr_wr(3'd2, 32'hA5A5_0009);
    push_desc(32'h1000, 32'h1040, 1'b1);
    wait_idle("single");
    csr_rd(3'd4, d);
    chk("single_done_count", d, 32'd1);
    repeat (2) @(negedge clk);
    chk("single_irq", {31'd0, irq}, 32'd1);
    csr_wr(3'd2, 32'hA5A5_000D);
    repeat (2) @(negedge clk);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Three back-to-back descriptors.
    done_dly = 5;
    push_desc(32'h1100, 32'h1200, 1'b1);
    push_desc(32'h1300, 32'h1400, 1'b1);
    push_desc(32'h1500, 32'h1600, 1'b1);
    wait_idle("three");
    csr_rd(3'd3, s);
    chk("three_empty", {31'd0, s[2]}, 32'd1);
    csr_rd(3'd4, d);
    chk("three_done_count", d, 32'd4);

    // Push rules with the scheduler disabled.
    exp_ctrl = 32'h00005A5A;
    csr_wr(3'd2, 32'h5A5A_0008);
    for (int i = 0; i < 11; i++) begin
      push_desc(vecs[i].b, vecs[i].e, vecs[i].acc);
      csr_rd(3'd3, s);
      chk($sformatf("vec%0d_occ", i), {24'd0, s[15:8]}, 32'(vecs[i].occ));
      csr_rd(3'd5, d);
      chk($sformatf("vec%0d_drop", i), d, 32'(vecs[i].drop));
    end
    csr_rd(3'd3, s);
    chk("fill_full", {31'd0, s[1]}, 32'd1);

    // Drain the full queue in order.
    done_dly = 3;
    csr_wr(3'd2, 32'h5A5A_0009);
    wait_idle("drain");
    csr_rd(3'd4, d);
    chk("drain_done_count", d, 32'd12);

    // Flush while a descriptor is in flight.
    done_dly = 40;
    push_desc(32'hA000, 32'hA100, 1'b1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) push_desc(32'hB000 + 32'(i) * 32'h100, 32'hB080 + 32'(i) * 32'h100, 1'b1);
    csr_rd(3'd3, s);
    chk("preflush_occ", {24'd0, s[15:8]}, 32'd4);
    sb.delete();
    csr_wr(3'd2, 32'h5A5A_000B);
    csr_rd(3'd3, s);
    chk("flush_occ", {24'd0, s[15:8]}, 32'd0);
    chk("flush_busy", {31'd0, s[0]}, 32'd1);
    wait_idle("flush");
    repeat (10) @(negedge clk);
    csr_rd(3'd4, d);
    chk("flush_done_count", d, 32'd13);

`ifdef PKT_SCHED_TIMEOUT_EN
    resp_en = 1'b0;
    push_desc(32'hC000, 32'hC040, 1'b1);
    repeat (40) @(negedge clk);
    csr_rd(3'd3, s);
    chk("timeout_status", s & 32'h9, 32'h8);
    csr_rd(3'd2, d);
    chk("timeout_enable", {31'd0, d[0]}, 32'd0);
    csr_rd(3'd4, d);
    chk("timeout_done_count", d, 32'd13);
`endif

    // Reset in the middle of an operation.
    resp_en = 1'b0;
    csr_wr(3'd2, 32'h5A5A_0009);
    push_desc(32'hD000, 32'hD100, 1'b1);
    push_desc(32'hD200, 32'hD300, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    csr_rd(3'd3, s);
    chk("midrst_status", s, 32'h4);
    csr_rd(3'd4, d);
    chk("midrst_done", d, 32'd0);
    csr_rd(3'd5, d);
    chk("midrst_drop", d, 32'd0);
    csr_rd(3'd2, d);
    chk("midrst_control", d, 32'd0);
    chk("midrst_eng_begin", eng_pkt_begin, 32'd0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
